// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: CPU-side memory/I/O bus controller.
//
// Decodes CPU byte addresses into RAM (0..IO_BASE-1), NDEV 16-byte peripheral
// slots starting at IO_BASE, and an unmapped remainder. Each access runs
// IDLE -> [WAIT] -> XFER -> RESP -> ACK. The number of WAIT cycles is set per
// region. Read data is registered into cpu_rdata.
//
// Optional feature, selected by the macro BIOS_OVERLAY_EN:
//   While the overlay is active, reads below BIOS_SIZE come from bios_rdata.
//   Writes there still go to RAM. The overlay switches off permanently (until
//   reset) at the first access to addr >= BIOS_SIZE. When the macro is
//   undefined, bios_active is held at 0 and bios_rdata is never selected.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   cpu_req/we/be/addr/wdata          CPU request (req is sampled in IDLE only)
//   cpu_rdata, cpu_ack, cpu_err       registered read data, completion pulse,
//                                     unmapped-access flag
//   ram_addr/wdata/be/we, ram_rdata   word-addressed RAM, 1-cycle read latency
//   bios_rdata                        boot ROM data, 1-cycle read latency
//   dev_sel/addr/wdata/we/re          peripheral slot bus
//   dev_rdata                         per-slot byte read data, 1-cycle latency
//   bios_active                       overlay status
module mem_bus_ctrl #(
  parameter int              AW           = 16,
  parameter logic [AW-1:0]   IO_BASE      = AW'(16'hff80),
  parameter int              NDEV         = 2,
  parameter logic [AW-1:0]   BIOS_SIZE    = AW'(16'h0800),
  parameter int              RAM_WS       = 0,
  parameter int              IO_WS        = 1,
  parameter logic [15:0]     UNMAPPED_VAL = 16'hcafe
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_be,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [AW-2:0]     ram_addr,
  output logic [15:0]       ram_wdata,
  output logic [1:0]        ram_be,
  output logic              ram_we,
  input  logic [15:0]       ram_rdata,
  input  logic [15:0]       bios_rdata,
  output logic [NDEV-1:0]   dev_sel,
  output logic [3:0]        dev_addr,
  output logic [7:0]        dev_wdata,
  output logic              dev_we,
  output logic              dev_re,
  input  logic [8*NDEV-1:0] dev_rdata,
  output logic              bios_active
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_XFER, S_RESP, S_ACK} state_t;
  typedef enum logic [1:0] {R_RAM, R_BIOS, R_DEV, R_NONE} region_t;

  state_t          state, state_d;
  region_t         rgn_q, rgn_d;
  logic [3:0]      cnt_q, ws_d;
  logic            we_q, be_q;
  logic [AW-1:0]   addr_q;
  logic [15:0]     wdata_q;
  logic [NDEV-1:0] sel_q, sel_d;
  logic            busy, mem_rgn;
  logic [AW-1:0]   io_off;
  logic            ram_hit, io_hit, bios_hit;
  logic [7:0]      dev_byte;
  logic [15:0]     mem_word, rdata_fmt;

  // ---------------- decode of the live CPU address ----------------
  assign ram_hit = cpu_addr < IO_BASE;
  assign io_off  = cpu_addr - IO_BASE;
  // io_off is only meaningful when the address is above IO_BASE.
  assign io_hit  = !ram_hit && ({1'b0, io_off} < (AW+1)'(16*NDEV));

`ifdef BIOS_OVERLAY_EN
  logic bios_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      bios_q <= 1'b1;
    else if (state == S_IDLE && cpu_req && cpu_addr >= BIOS_SIZE)
      bios_q <= 1'b0;
  assign bios_active = bios_q;
  assign bios_hit    = bios_q && (cpu_addr < BIOS_SIZE);
`else
  assign bios_active = 1'b0;
  assign bios_hit    = 1'b0;
`endif

  always_comb begin
    sel_d = '0;
    for (int i = 0; i < NDEV; i++)
      sel_d[i] = io_hit && (io_off[AW-1:4] == (AW-4)'(i));
    rgn_d = R_NONE;
    ws_d  = 4'd0;
    // Overlay only diverts reads; shadow writes land in RAM.
    if (bios_hit && !cpu_we) begin
      rgn_d = R_BIOS;
      ws_d  = 4'(RAM_WS);
    end else if (ram_hit) begin
      rgn_d = R_RAM;
      ws_d  = 4'(RAM_WS);
    end else if (io_hit) begin
      rgn_d = R_DEV;
      ws_d  = 4'(IO_WS);
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (cpu_req) state_d = (ws_d != 4'd0) ? S_WAIT : S_XFER;
      S_WAIT: if (cnt_q == 4'd1) state_d = S_XFER;
      S_XFER: state_d = S_RESP;
      S_RESP: state_d = S_ACK;
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rgn_q     <= R_NONE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      be_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      cpu_rdata <= '0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: if (cpu_req) begin
          we_q    <= cpu_we;
          be_q    <= cpu_be;
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
          rgn_q   <= rgn_d;
          sel_q   <= sel_d;
          cnt_q   <= ws_d;
        end
        S_WAIT: cnt_q <= cnt_q - 4'd1;
        S_RESP: if (!we_q) cpu_rdata <= rdata_fmt;
        default: ;
      endcase
    end
  end

  // ---------------- read data formatting (RESP) ----------------
  always_comb begin
    dev_byte = 8'h00;
    for (int i = 0; i < NDEV; i++)
      if (sel_q[i]) dev_byte = dev_rdata[8*i +: 8];
    mem_word = (rgn_q == R_BIOS) ? bios_rdata : ram_rdata;
    if (rgn_q == R_DEV)       rdata_fmt = {8'h00, dev_byte};
    else if (rgn_q == R_NONE) rdata_fmt = UNMAPPED_VAL;
    else if (be_q)            rdata_fmt = {8'h00, addr_q[0] ? mem_word[7:0] : mem_word[15:8]};
    else                      rdata_fmt = mem_word;
  end

  // ---------------- bus outputs ----------------
  assign busy      = state != S_IDLE;
  assign mem_rgn   = (rgn_q == R_RAM) || (rgn_q == R_BIOS);
  assign ram_addr  = busy ? addr_q[AW-1:1] : '0;
  assign dev_addr  = busy ? addr_q[3:0]    : 4'd0;
  assign dev_sel   = busy ? sel_q          : '0;
  assign dev_wdata = busy ? wdata_q[7:0]   : 8'h00;

  // Odd byte address is the low lane.
  assign ram_be    = !be_q ? 2'b11 : (addr_q[0] ? 2'b01 : 2'b10);
  assign ram_wdata = !be_q ? wdata_q :
                     (addr_q[0] ? {8'h00, wdata_q[7:0]} : {wdata_q[7:0], 8'h00});

  assign ram_we  = (state == S_XFER) && we_q && mem_rgn;
  assign dev_we  = (state == S_XFER) && we_q && (rgn_q == R_DEV);
  assign dev_re  = (state == S_XFER) && !we_q && (rgn_q == R_DEV);
  assign cpu_ack = state == S_ACK;
  assign cpu_err = cpu_ack && (rgn_q == R_NONE);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: the driver computes each access's
// expected response from an abstract memory/device model and queues it; a
// negedge monitor collects strobes and checks each ack against the queue.
module tb_mem_bus_ctrl;
  localparam int          AW = 16, NDEV = 2, RAM_WS = 0, IO_WS = 2;
  localparam logic [15:0] IO_BASE = 16'hff80, BIOS_SIZE = 16'h0800, UNMAPPED = 16'hcafe;
`ifdef BIOS_OVERLAY_EN
  localparam bit BIOS_EN = 1'b1;
`else
  localparam bit BIOS_EN = 1'b0;
`endif

  logic clk, rst_n;
  logic cpu_req, cpu_we, cpu_be;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic cpu_ack, cpu_err;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata, bios_rdata;
  logic [1:0] ram_be;
  logic ram_we;
  logic [NDEV-1:0] dev_sel;
  logic [3:0] dev_addr;
  logic [7:0] dev_wdata;
  logic dev_we, dev_re;
  logic [8*NDEV-1:0] dev_rdata;
  logic bios_active;

  mem_bus_ctrl #(.AW(AW), .IO_BASE(IO_BASE), .NDEV(NDEV), .BIOS_SIZE(BIOS_SIZE),
                 .RAM_WS(RAM_WS), .IO_WS(IO_WS), .UNMAPPED_VAL(UNMAPPED)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cpu_err(cpu_err), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
    .ram_we(ram_we), .ram_rdata(ram_rdata), .bios_rdata(bios_rdata), .dev_sel(dev_sel),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_we(dev_we), .dev_re(dev_re),
    .dev_rdata(dev_rdata), .bios_active(bios_active));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bus sinks (environment) ----------------
  bit [15:0] ram_mem [0:32767];
  bit [15:0] bios_mem [0:1023];
  bit [7:0]  dev_mem [0:NDEV-1][0:15];

  always @(posedge clk) begin
    if (ram_we) begin
      if (ram_be[1]) ram_mem[ram_addr][15:8] <= ram_wdata[15:8];
      if (ram_be[0]) ram_mem[ram_addr][7:0]  <= ram_wdata[7:0];
    end
    ram_rdata  <= ram_mem[ram_addr];
    bios_rdata <= bios_mem[ram_addr[9:0]];
  end

  always @(posedge clk)
    for (int i = 0; i < NDEV; i++) begin
      dev_rdata[8*i +: 8] <= dev_mem[i][dev_addr];
      if (dev_we && dev_sel[i]) dev_mem[i][dev_addr] <= dev_wdata;
    end

  // ---------------- reference model ----------------
  typedef struct {
    bit rd; bit [15:0] rdata; bit err; bit bios; int lat; int issue;
    int n_ram_we; bit [14:0] waddr; bit [1:0] be; bit [15:0] wd;
    int n_dev_we; int n_dev_re; bit [NDEV-1:0] sel; bit [3:0] daddr; bit [7:0] dwd;
  } exp_t;

  exp_t q[$];
  bit [15:0] mdl_ram [0:32767];
  bit [7:0]  mdl_dev [0:NDEV-1][0:15];
  bit        mdl_bios;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int acks = 0, c_rwe = 0, c_dwe = 0, c_dre = 0;
  logic [14:0] c_waddr; logic [1:0] c_be; logic [15:0] c_wd;
  logic [NDEV-1:0] c_sel; logic [3:0] c_daddr; logic [7:0] c_dwd;
  exp_t me;

  always @(negedge clk) if (rst_n) begin
    if (ram_we) begin c_rwe++; c_waddr = ram_addr; c_be = ram_be; c_wd = ram_wdata; end
    if (dev_we) begin c_dwe++; c_sel = dev_sel; c_daddr = dev_addr; c_dwd = dev_wdata; end
    if (dev_re) begin c_dre++; c_sel = dev_sel; c_daddr = dev_addr; end
    if (cpu_err && !cpu_ack) chk("err_without_ack", cpu_err, cpu_ack);
    if (cpu_ack) begin
      if (q.size() == 0) chk("spurious_ack", cpu_ack, 1'b0);
      else begin
        me = q.pop_front();
        chk("latency", cyc - me.issue, me.lat);
        chk("cpu_err", cpu_err, me.err);
        chk("bios_active", bios_active, me.bios);
        if (me.rd) chk("cpu_rdata", cpu_rdata, me.rdata);
        chk("ram_we_pulses", c_rwe, me.n_ram_we);
        chk("dev_we_pulses", c_dwe, me.n_dev_we);
        chk("dev_re_pulses", c_dre, me.n_dev_re);
        if (me.n_ram_we == 1) begin
          chk("ram_addr", c_waddr, me.waddr);
          chk("ram_be", c_be, me.be);
          chk("ram_wdata", c_wd, me.wd);
        end
        if (me.n_dev_we + me.n_dev_re == 1) begin
          chk("dev_sel", c_sel, me.sel);
          chk("dev_addr", c_daddr, me.daddr);
        end
        if (me.n_dev_we == 1) chk("dev_wdata", c_dwd, me.dwd);
      end
      c_rwe = 0; c_dwe = 0; c_dre = 0;
      acks++;
    end
  end

  // ---------------- driver ----------------
  task automatic access(input bit we, input bit be, input logic [15:0] addr, input logic [15:0] wd);
    exp_t e; int a0; bit [15:0] w; int slot;
    e = '{default: 0};
    e.rd = !we;
    if (addr < IO_BASE) begin
      e.lat = RAM_WS + 3;
      if (we) begin
        e.n_ram_we = 1; e.waddr = addr[15:1];
        if (!be) begin
          e.be = 2'b11; e.wd = wd; mdl_ram[addr[15:1]] = wd;
        end else if (addr[0]) begin
          e.be = 2'b01; e.wd = {8'h00, wd[7:0]}; mdl_ram[addr[15:1]][7:0] = wd[7:0];
        end else begin
          e.be = 2'b10; e.wd = {wd[7:0], 8'h00}; mdl_ram[addr[15:1]][15:8] = wd[7:0];
        end
      end else begin
        w = (mdl_bios && addr < BIOS_SIZE) ? bios_mem[addr[10:1]] : mdl_ram[addr[15:1]];
        e.rdata = !be ? w : (addr[0] ? {8'h00, w[7:0]} : {8'h00, w[15:8]});
      end
    end else if (32'(addr) < 32'(IO_BASE) + 16 * NDEV) begin
      slot = (int'(addr) - int'(IO_BASE)) / 16;
      e.lat = IO_WS + 3; e.sel = NDEV'(1 << slot); e.daddr = addr[3:0];
      if (we) begin
        e.n_dev_we = 1; e.dwd = wd[7:0]; mdl_dev[slot][addr[3:0]] = wd[7:0];
      end else begin
        e.n_dev_re = 1; e.rdata = {8'h00, mdl_dev[slot][addr[3:0]]};
      end
    end else begin
      e.lat = 3; e.err = 1'b1;
      if (!we) e.rdata = UNMAPPED;
    end
    if (addr >= BIOS_SIZE) mdl_bios = 1'b0;
    e.bios = mdl_bios;

    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
    e.issue = cyc; q.push_back(e); a0 = acks;
    // Keep req high with garbage for one more cycle: it must be ignored.
    @(posedge clk); #1;
    cpu_we = 1'($urandom); cpu_be = 1'($urandom);
    cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    for (int k = 0; k < 40 && acks == a0; k++) @(negedge clk);
    if (acks == a0) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout: no ack for addr %h within 40 cycles", addr);
      q.delete();
    end
  endtask

  function automatic logic [15:0] rnd_addr();
    int r; logic [15:0] base;
    r = $urandom_range(0, 9);
    if (r <= 4) begin
      case ($urandom_range(0, 3))
        0: base = 16'h0000;
        1: base = 16'h0100;
        2: base = 16'h07e0;
        default: base = IO_BASE - 16'd32;
      endcase
      return base + 16'($urandom_range(0, 31));
    end else if (r <= 8) return IO_BASE + 16'($urandom_range(0, 16 * NDEV - 1));
    else return 16'($urandom_range(int'(IO_BASE) + 16 * NDEV, 16'hffff));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_before;
    for (int i = 0; i < 1024; i++) bios_mem[i] = 16'($urandom);
    bios_mem[8] = 16'hBEEF;
    mdl_bios = BIOS_EN;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    #1;
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_cpu_rdata", cpu_rdata, 16'h0000);
    chk("rst_bios_active", bios_active, BIOS_EN);
    chk("rst_strobes", {ram_we, dev_we, dev_re, cpu_err}, 4'b0000);
    chk("rst_dev_sel", dev_sel, '0);
    #21 rst_n = 1'b1;

    // overlay sequence
    access(1'b0, 1'b0, 16'h0010, 16'h0);
    access(1'b0, 1'b0, 16'h0800, 16'h0);
    access(1'b0, 1'b0, 16'h0010, 16'h0);
    // word / byte lanes
    access(1'b1, 1'b0, 16'h0100, 16'h1234);
    access(1'b0, 1'b0, 16'h0100, 16'h0);
    access(1'b1, 1'b1, 16'h0101, 16'h00AB);
    access(1'b1, 1'b1, 16'h0100, 16'h00CD);
    access(1'b0, 1'b1, 16'h0101, 16'h0);
    access(1'b0, 1'b1, 16'h0100, 16'h0);
    access(1'b0, 1'b0, 16'h0100, 16'h0);
    // devices, last RAM word, unmapped
    access(1'b1, 1'b1, 16'hff93, 16'h775A);
    access(1'b0, 1'b0, 16'hff93, 16'h0);
    access(1'b1, 1'b0, 16'hff7e, 16'h9abc);
    access(1'b0, 1'b0, 16'hff7e, 16'h0);
    access(1'b0, 1'b0, 16'hffa0, 16'h0);
    access(1'b1, 1'b0, 16'hffa0, 16'h5555);
    access(1'b0, 1'b1, 16'hffff, 16'h0);

    // reset in the WAIT of a device write
    a_before = acks;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 1'b1; cpu_addr = 16'hff85; cpu_wdata = 16'h00ee;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cpu_ack", cpu_ack, 1'b0);
    chk("abort_strobes", {ram_we, dev_we, dev_re}, 3'b000);
    chk("abort_dev_sel", dev_sel, '0);
    chk("abort_cpu_rdata", cpu_rdata, 16'h0000);
    chk("abort_bios_active", bios_active, BIOS_EN);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mdl_bios = BIOS_EN;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_dev_we", c_dwe, 0);
    chk("abort_no_ack", acks, a_before);
    access(1'b0, 1'b1, 16'hff85, 16'h0);
    access(1'b0, 1'b0, 16'h0010, 16'h0);

    for (int n = 0; n < 300; n++)
      access(1'($urandom), 1'($urandom), rnd_addr(), 16'($urandom));

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
